// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory subsystem: SDRAM window geometry,
// arbiter state encoding and the core-to-SDRAM address translation.
package gpu_mem_pkg;

    localparam int WORD_WIDTH          = 32;
    localparam int GPU_ADDRESS_WIDTH   = 24;
    localparam int SDRAM_ADDRESS_WIDTH = 30;
    localparam logic [SDRAM_ADDRESS_WIDTH-1:0] SDRAM_BASE = 30'h3E000000;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    // The sum wraps modulo 2^SDRAM_ADDRESS_WIDTH; the byte offset bits are dropped.
    function automatic logic [SDRAM_ADDRESS_WIDTH-1:0] sdram_word_address(
        input logic [GPU_ADDRESS_WIDTH-1:0] byte_addr
    );
        logic [SDRAM_ADDRESS_WIDTH-1:0] sum;
        sum = SDRAM_ADDRESS_WIDTH'(byte_addr) + SDRAM_BASE;
        return sum >> 2;
    endfunction

endpackage

// File: rtl/gpu_sdram_arbiter_if.sv
// Bundle of per-core Avalon ports and the shared SDRAM master port.
// master = the arbiter; slave = the surrounding cores and SDRAM controller.
interface gpu_sdram_arbiter_if
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CORES = 4
) ();

    logic [NUM_CORES*GPU_ADDRESS_WIDTH-1:0] core_address;
    logic [NUM_CORES-1:0]                   core_read;
    logic [NUM_CORES-1:0]                   core_write;
    logic [NUM_CORES*WORD_WIDTH-1:0]        core_writedata;
    logic [NUM_CORES-1:0]                   core_waitrequest;
    logic [WORD_WIDTH-1:0]                  core_readdata;
    logic [NUM_CORES-1:0]                   core_readdatavalid;

    logic [SDRAM_ADDRESS_WIDTH-1:0]         sdram_address;
    logic                                   sdram_read;
    logic                                   sdram_write;
    logic [WORD_WIDTH-1:0]                  sdram_writedata;
    logic                                   sdram_waitrequest;
    logic [WORD_WIDTH-1:0]                  sdram_readdata;
    logic                                   sdram_readdatavalid;

    modport master (
        input  core_address, core_read, core_write, core_writedata,
        input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
        output core_waitrequest, core_readdata, core_readdatavalid,
        output sdram_address, sdram_read, sdram_write, sdram_writedata
    );

    modport slave (
        output core_address, core_read, core_write, core_writedata,
        output sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
        input  core_waitrequest, core_readdata, core_readdatavalid,
        input  sdram_address, sdram_read, sdram_write, sdram_writedata
    );

endinterface

// File: rtl/gpu_sdram_arbiter_pending_read_fifo.sv
// In-order tag FIFO recording which core owns each outstanding SDRAM read.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module pending_read_fifo #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [TAG_W-1:0]       data_in,
    output logic [TAG_W-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage holds no control state, so it is left out of reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: rtl/gpu_sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master among NUM_CORES GPU cores,
// with an in-order tag FIFO steering each read-data beat back to its issuing core.
module gpu_sdram_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int MAX_PENDING = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    gpu_sdram_arbiter_if.master          bus,
    output logic [$clog2(MAX_PENDING):0] pending_count,
    output logic                         return_error
);

    localparam int GW = $clog2(NUM_CORES);
    localparam int CW = $clog2(MAX_PENDING) + 1;

    arb_state_e                     state_q, state_d;
    logic [GW-1:0]                  grant_q, grant_d;
    logic [GW-1:0]                  last_grant_q, last_grant_d;
    logic                           is_write_q, is_write_d;
    logic                           sdram_read_q, sdram_read_d;
    logic                           sdram_write_q, sdram_write_d;
    logic                           return_error_q, return_error_d;
    logic [SDRAM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]          wdata_q, wdata_d;

    logic [GPU_ADDRESS_WIDTH-1:0]   core_addr  [NUM_CORES];
    logic [WORD_WIDTH-1:0]          core_wdata [NUM_CORES];
    logic [NUM_CORES-1:0]           eligible;
    logic [NUM_CORES-1:0]           core_wait;
    logic [NUM_CORES-1:0]           core_rdv;
    logic [GW-1:0]                  cand;
    logic                           found;
    logic                           accept;
    logic                           push;
    logic                           pop;
    logic [GW-1:0]                  fifo_head;
    logic [CW-1:0]                  fifo_count;
    logic                           fifo_full;
    logic                           fifo_empty;

    // A core raising read and write together counts as a write, which never waits on the FIFO.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        assign core_addr[i]  = bus.core_address[i*GPU_ADDRESS_WIDTH +: GPU_ADDRESS_WIDTH];
        assign core_wdata[i] = bus.core_writedata[i*WORD_WIDTH +: WORD_WIDTH];
        assign eligible[i]   = bus.core_write[i] | (bus.core_read[i] & ~fifo_full);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        is_write_d    = is_write_q;
        sdram_read_d  = sdram_read_q;
        sdram_write_d = sdram_write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        accept        = 1'b0;
        found         = 1'b0;
        cand          = '0;
        case (state_q)
            IDLE: begin
                for (int k = 1; k <= NUM_CORES; k++) begin
                    cand = GW'((int'(last_grant_q) + k) % NUM_CORES);
                    if (!found && eligible[cand]) begin
                        found      = 1'b1;
                        grant_d    = cand;
                        is_write_d = bus.core_write[cand];
                        addr_d     = sdram_word_address(core_addr[cand]);
                        wdata_d    = core_wdata[cand];
                    end
                end
                if (found) begin
                    state_d       = ISSUE;
                    sdram_read_d  = ~is_write_d;
                    sdram_write_d = is_write_d;
                end
            end
            ISSUE: begin
                if (!bus.sdram_waitrequest) begin
                    accept        = 1'b1;
                    last_grant_d  = grant_q;
                    state_d       = IDLE;
                    sdram_read_d  = 1'b0;
                    sdram_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_wait = '1;
        if (accept) core_wait[grant_q] = 1'b0;
    end

    // A beat with no recorded owner is dropped and latched as an error.
    always_comb begin
        core_rdv       = '0;
        return_error_d = return_error_q;
        if (pop) begin
            if (fifo_empty) return_error_d = 1'b1;
            else            core_rdv[fifo_head] = 1'b1;
        end
    end

    assign push = accept & ~is_write_q;
    assign pop  = bus.sdram_readdatavalid;

    pending_read_fifo #(
        .DEPTH (MAX_PENDING),
        .TAG_W (GW)
    ) u_tags (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (grant_q),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_grant_q   <= GW'(NUM_CORES - 1);
            is_write_q     <= 1'b0;
            sdram_read_q   <= 1'b0;
            sdram_write_q  <= 1'b0;
            return_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            is_write_q     <= is_write_d;
            sdram_read_q   <= sdram_read_d;
            sdram_write_q  <= sdram_write_d;
            return_error_q <= return_error_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign bus.sdram_address      = addr_q;
    assign bus.sdram_writedata    = wdata_q;
    assign bus.sdram_read         = sdram_read_q;
    assign bus.sdram_write        = sdram_write_q;
    assign bus.core_waitrequest   = core_wait;
    assign bus.core_readdatavalid = core_rdv;
    assign bus.core_readdata      = bus.sdram_readdata;
    assign pending_count          = fifo_count;
    assign return_error           = return_error_q;

endmodule

// File: tb/tb_gpu_sdram_arbiter.sv
// Bench for gpu_sdram_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized cores and SDRAM slave.
module tb_gpu_sdram_arbiter;

    localparam int N    = 4;
    localparam int MAXP = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pending_count;
    logic       return_error;

    gpu_sdram_arbiter_if #(.NUM_CORES(N)) bus ();

    gpu_sdram_arbiter #(
        .NUM_CORES   (N),
        .MAX_PENDING (MAXP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .pending_count (pending_count),
        .return_error  (return_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one command slot, last winner, queue of read owners, sticky error.
    bit          m_busy;
    int          m_core;
    bit          m_wr;
    logic [29:0] m_addr;
    logic [31:0] m_data;
    int          m_last;
    int          m_tags[$];
    bit          m_err;
    logic [N-1:0] m_acc_mask;
    bit          m_acc_read;
    logic [N-1:0] obs_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [29:0] word_addr(input logic [23:0] a);
        longint s;
        s = (longint'(a) + 64'h3E000000) % 64'h40000000;
        return 30'(s / 4);
    endfunction

    task automatic tick();
        logic [N-1:0] exp_wait;
        logic [N-1:0] exp_rdv;
        int nb;
        bit acc;
        @(negedge clock);
        m_acc_mask = '0;
        m_acc_read = 1'b0;
        obs_acc    = ~bus.core_waitrequest;
        if (reset) begin
            m_busy = 1'b0;
            m_last = N - 1;
            m_tags.delete();
            m_err  = 1'b0;
            chk("rst_core_waitrequest", bus.core_waitrequest, {N{1'b1}});
            chk("rst_core_readdatavalid", bus.core_readdatavalid, 0);
            chk("rst_sdram_read", bus.sdram_read, 0);
            chk("rst_sdram_write", bus.sdram_write, 0);
            chk("rst_pending_count", pending_count, 0);
            chk("rst_return_error", return_error, 0);
        end else begin
            acc      = m_busy && !bus.sdram_waitrequest;
            exp_wait = acc ? ~N'(1 << m_core) : {N{1'b1}};
            exp_rdv  = (bus.sdram_readdatavalid && m_tags.size() > 0) ? N'(1 << m_tags[0]) : '0;
            chk("sdram_read", bus.sdram_read, m_busy && !m_wr);
            chk("sdram_write", bus.sdram_write, m_busy && m_wr);
            if (m_busy) chk("sdram_address", bus.sdram_address, m_addr);
            if (m_busy && m_wr) chk("sdram_writedata", bus.sdram_writedata, m_data);
            chk("core_waitrequest", bus.core_waitrequest, exp_wait);
            chk("core_readdatavalid", bus.core_readdatavalid, exp_rdv);
            if (bus.sdram_readdatavalid) chk("core_readdata", bus.core_readdata, bus.sdram_readdata);
            chk("pending_count", pending_count, m_tags.size());
            chk("return_error", return_error, m_err);
            nb = m_tags.size();
            if (bus.sdram_readdatavalid) begin
                if (nb > 0) void'(m_tags.pop_front());
                else        m_err = 1'b1;
            end
            if (acc) begin
                if (!m_wr) m_tags.push_back(m_core);
                m_last             = m_core;
                m_busy             = 1'b0;
                m_acc_mask[m_core] = 1'b1;
                m_acc_read         = !m_wr;
            end else if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (bus.core_write[c] || (bus.core_read[c] && nb < MAXP)) begin
                        m_busy = 1'b1;
                        m_core = c;
                        m_wr   = bus.core_write[c];
                        m_addr = word_addr(bus.core_address[c*24 +: 24]);
                        m_data = bus.core_writedata[c*32 +: 32];
                        break;
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_read           = '0;
        bus.core_write          = '0;
        bus.core_address        = '0;
        bus.core_writedata      = '0;
        bus.sdram_waitrequest   = 1'b0;
        bus.sdram_readdatavalid = 1'b0;
        bus.sdram_readdata      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_core(input int i, input bit rd, input bit wr,
                            input logic [23:0] a, input logic [31:0] d);
        bus.core_read[i]              = rd;
        bus.core_write[i]             = wr;
        bus.core_address[i*24 +: 24]  = a;
        bus.core_writedata[i*32 +: 32] = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order[$];
        int drops[N];
        int ret_q[$];
        int last_ret;
        int t;
        idle_inputs();
        do_reset();
        chk("reset_pending_count", pending_count, 0);
        chk("reset_return_error", return_error, 0);
        chk("reset_core_waitrequest", bus.core_waitrequest, 4'hF);

        // Single read from core 1
        set_core(1, 1, 0, 24'h000100, 32'h0);
        tick();
        chk("t1_sdram_address", bus.sdram_address, 30'h0F800040);
        chk("t1_sdram_read", bus.sdram_read, 1);
        chk("t1_core_waitrequest", bus.core_waitrequest, 4'b1101);
        tick();
        set_core(1, 0, 0, 24'h0, 32'h0);
        chk("t1_pending_1", pending_count, 1);
        tick();
        tick();
        bus.sdram_readdatavalid = 1'b1;
        bus.sdram_readdata      = 32'hCAFEF00D;
        #1;
        chk("t1_readdatavalid", bus.core_readdatavalid, 4'b0010);
        chk("t1_readdata", bus.core_readdata, 32'hCAFEF00D);
        tick();
        bus.sdram_readdatavalid = 1'b0;
        chk("t1_pending_0", pending_count, 0);

        // Round-robin with all cores writing continuously
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 0, 1, 24'($urandom), $urandom);
        for (int i = 0; i < N; i++) drops[i] = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (obs_acc[i]) begin order.push_back(i); drops[i]++; end
        end
        chk("t2_grants", order.size(), 8);
        for (int j = 0; j < order.size() && j < 8; j++) chk("t2_order", order[j], j % 4);
        for (int i = 0; i < N; i++) chk("t2_drops", drops[i], 2);

        // Backpressure on a core 2 write
        do_reset();
        set_core(2, 0, 1, 24'h000010, 32'h12345678);
        bus.sdram_waitrequest = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t3_address_stable", bus.sdram_address, 30'h0F800004);
            chk("t3_data_stable", bus.sdram_writedata, 32'h12345678);
            chk("t3_wait_high", bus.core_waitrequest, 4'hF);
            tick();
        end
        bus.sdram_waitrequest = 1'b0;
        #1;
        chk("t3_accept_wait", bus.core_waitrequest, 4'b1011);
        tick();
        set_core(2, 0, 0, 24'h0, 32'h0);
        chk("t3_write_done", bus.sdram_write, 0);

        // FIFO full: reads stall, writes proceed
        do_reset();
        set_core(0, 1, 0, 24'h000200, 32'h0);
        repeat (16) tick();
        chk("t4_full_count", pending_count, 8);
        set_core(3, 0, 1, 24'h000300, 32'hA5A5A5A5);
        tick();
        chk("t4_write_issued", bus.sdram_write, 1);
        chk("t4_read_blocked", bus.sdram_read, 0);
        chk("t4_write_accept", bus.core_waitrequest, 4'b0111);
        tick();
        set_core(3, 0, 0, 24'h0, 32'h0);
        repeat (3) begin
            tick();
            chk("t4_read_stalled", bus.sdram_read, 0);
        end
        bus.sdram_readdatavalid = 1'b1;
        bus.sdram_readdata      = 32'h00000001;
        tick();
        bus.sdram_readdatavalid = 1'b0;
        tick();
        chk("t4_read_issued", bus.sdram_read, 1);
        tick();
        set_core(0, 0, 0, 24'h0, 32'h0);
        chk("t4_refilled", pending_count, 8);
        bus.sdram_readdatavalid = 1'b1;
        repeat (8) tick();
        bus.sdram_readdatavalid = 1'b0;
        chk("t4_drained", pending_count, 0);

        // Tag routing with a return coinciding with an acceptance
        do_reset();
        set_core(3, 1, 0, 24'h000030, 32'h0);
        tick(); tick();
        set_core(3, 0, 0, 24'h0, 32'h0);
        set_core(0, 1, 0, 24'h000040, 32'h0);
        tick(); tick();
        set_core(0, 0, 0, 24'h0, 32'h0);
        set_core(2, 1, 0, 24'h000050, 32'h0);
        tick();
        bus.sdram_readdatavalid = 1'b1;
        bus.sdram_readdata      = 32'h33;
        #1;
        chk("t5_strobe_core3", bus.core_readdatavalid, 4'b1000);
        chk("t5_accept_core2", bus.core_waitrequest, 4'b1011);
        tick();
        set_core(2, 0, 0, 24'h0, 32'h0);
        chk("t5_count_after_pushpop", pending_count, 2);
        bus.sdram_readdata = 32'h44;
        #1;
        chk("t5_strobe_core0", bus.core_readdatavalid, 4'b0001);
        tick();
        bus.sdram_readdata = 32'h55;
        #1;
        chk("t5_strobe_core2", bus.core_readdatavalid, 4'b0100);
        tick();
        bus.sdram_readdatavalid = 1'b0;
        chk("t5_count_empty", pending_count, 0);

        // Return with empty FIFO, then reset with reads pending
        do_reset();
        bus.sdram_readdatavalid = 1'b1;
        #1;
        chk("t6_no_strobe", bus.core_readdatavalid, 4'b0000);
        tick();
        bus.sdram_readdatavalid = 1'b0;
        chk("t6_error_set", return_error, 1);
        set_core(1, 1, 0, 24'h000400, 32'h0);
        repeat (4) tick();
        set_core(1, 0, 0, 24'h0, 32'h0);
        chk("t6_two_pending", pending_count, 2);
        chk("t6_error_sticky", return_error, 1);
        reset = 1'b1;
        #1;
        chk("t6_reset_count", pending_count, 0);
        chk("t6_reset_error", return_error, 0);
        tick();
        reset = 1'b0;
        bus.sdram_readdatavalid = 1'b1;
        tick();
        bus.sdram_readdatavalid = 1'b0;
        chk("t6_late_beat_error", return_error, 1);

        // Randomized cores and slave, then a drain period with no new requests
        do_reset();
        last_ret = 0;
        for (int cyc = 0; cyc < 4300; cyc++) begin
            bit gen;
            bit slow;
            gen  = (cyc < 4000);
            slow = ((cyc / 500) % 2) == 1;
            for (int i = 0; i < N; i++) begin
                if (m_acc_mask[i]) set_core(i, 0, 0, 24'h0, 32'h0);
                if (gen && !(bus.core_read[i] || bus.core_write[i]) && $urandom_range(0, 3) == 0) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    set_core(i, kind != 1, kind != 0, 24'($urandom), $urandom);
                end
            end
            bus.sdram_waitrequest = gen ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                void'(ret_q.pop_front());
                bus.sdram_readdatavalid = 1'b1;
                bus.sdram_readdata      = $urandom;
            end else begin
                bus.sdram_readdatavalid = 1'b0;
            end
            tick();
            if (m_acc_read) begin
                t = cyc + 1 + (slow ? int'($urandom_range(4, 30)) : int'($urandom_range(0, 4)));
                if (t <= last_ret) t = last_ret + 1;
                last_ret = t;
                ret_q.push_back(t);
            end
        end
        idle_inputs();
        tick();
        chk("rand_returns_outstanding", ret_q.size(), 0);
        chk("rand_final_pending", pending_count, 0);
        chk("rand_no_error", return_error, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
